// File: rtl/twiddle_fetcher.sv
// twiddle_fetcher: sequences twiddle ROM reads for one radix-2 DIT butterfly stage and
// streams the words out through a 3-entry FIFO. Define TWIDDLE_FETCHER_CONJ_EN to conjugate (negate im).
module twiddle_fetcher #(
    parameter int N_LOG2 = 9,
    parameter int TF_W   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             stage,
    output logic [N_LOG2-2:0]      tf_addr,
    output logic                   tf_addr_nd,
    input  logic [2*TF_W-1:0]      tf_in,
    output logic signed [TF_W-1:0] tw_re,
    output logic signed [TF_W-1:0] tw_im,
    output logic [N_LOG2-2:0]      tw_addr,
    output logic                   tw_last,
    output logic                   tw_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);
    localparam int A_W   = N_LOG2 - 1;
    localparam int DEPTH = 3;
    localparam logic [A_W-1:0] J_LAST = '1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic signed [TF_W-1:0] re;
        logic signed [TF_W-1:0] im;
        logic [A_W-1:0]         addr;
        logic                   last;
    } entry_t;

    state_t         state_q, state_d;
    logic [A_W-1:0] j_q;
    logic [3:0]     stage_q;
    logic           req_last_q;
    logic           rd_pend_q;
    logic [A_W-1:0] rd_addr_q;
    logic           rd_last_q;
    entry_t         fifo_q [DEPTH];
    logic [1:0]     wr_ptr_q, rd_ptr_q, count_q;
    entry_t         head, cap;
    logic           start_ok, issue_first, issue_next, issue;
    logic           push, pop, room;
    logic [2:0]     committed;

    // Butterfly j of stage s uses twiddle (j mod 2^s) * 2^(A_W-s).
    function automatic logic [A_W-1:0] addr_of(input logic [A_W-1:0] j, input logic [3:0] s);
        logic [A_W:0] mask;
        mask = ((A_W+1)'(1) << s) - (A_W+1)'(1);
        return A_W'(({1'b0, j} & mask) << (A_W - int'(s)));
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign start_ok = start && (int'(stage) < N_LOG2);
    assign head     = fifo_q[rd_ptr_q];
    assign tw_valid = (count_q != 2'd0);
    assign pop      = tw_valid & out_ready;
    assign push     = rd_pend_q;

    // Words already committed to the FIFO next cycle: stored, returning, requested, less this pop.
    assign committed = {1'b0, count_q} + {2'b0, rd_pend_q} + {2'b0, tf_addr_nd} - {2'b0, pop};
    assign room      = (committed < 3'd3);
    assign issue     = issue_first | issue_next;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= pop & head.last;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = FETCH;
            FETCH:   if (issue_next && (j_q == J_LAST)) state_d = DRAIN;
            DRAIN:   if (pop && head.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        busy        = 1'b0;
        issue_first = 1'b0;
        issue_next  = 1'b0;
        case (state_q)
            IDLE:  issue_first = start_ok;
            FETCH: begin
                busy       = 1'b1;
                issue_next = room;
            end
            DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    // Request side: the strobe is a flop, so out_ready only reaches it through the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_addr_nd <= 1'b0;
            tf_addr    <= '0;
            j_q        <= '0;
            stage_q    <= '0;
            req_last_q <= 1'b0;
        end else begin
            tf_addr_nd <= issue;
            if (issue_first) begin
                stage_q    <= stage;
                tf_addr    <= '0;
                j_q        <= A_W'(1);
                req_last_q <= (J_LAST == '0);
            end else if (issue_next) begin
                tf_addr    <= addr_of(j_q, stage_q);
                req_last_q <= (j_q == J_LAST);
                j_q        <= j_q + A_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_pend_q <= tf_addr_nd;
            if (tf_addr_nd) begin
                rd_addr_q <= tf_addr;
                rd_last_q <= req_last_q;
            end
        end
    end

    always_comb begin
        cap.re = tf_in[2*TF_W-1:TF_W];
`ifdef TWIDDLE_FETCHER_CONJ_EN
        cap.im = -tf_in[TF_W-1:0];
`else
        cap.im = tf_in[TF_W-1:0];
`endif
        cap.addr = rd_addr_q;
        cap.last = rd_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the three storage entries are reset so tw_* read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= cap;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    assign tw_re   = head.re;
    assign tw_im   = head.im;
    assign tw_addr = head.addr;
    assign tw_last = head.last;

endmodule
